// File: rtl/switch_pkg.sv
// Shared descriptor layout, port count and scheduler state encoding.
// Header-only package: no timing, no back-pressure of its own.
package switch_pkg;

    localparam int NPORT     = 4;
    localparam int DESC_W    = 16;
    localparam int START_LSB = 0;
    localparam int START_W   = 8;
    localparam int CNT_LSB   = 8;
    localparam int CNT_W     = 6;
    localparam int RSV_LSB   = 14;
    localparam int RSV_W     = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    function automatic logic [NPORT-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/switch_egress_sched_if.sv
// Bundle of queue, cell-memory and cell-output signals around the egress scheduler.
// Pure wiring: the scheduler owns q_rd/mem_rd/o_cell_*; the environment owns the rest.
interface switch_egress_sched_if #(
    parameter int AW = 8,
    parameter int DW = 128
) ();
    import switch_pkg::*;

    logic [NPORT-1:0]        q_empty;
    logic [NPORT*DESC_W-1:0] q_head;
    logic [NPORT-1:0]        q_rd;
    logic                    mem_rd;
    logic [AW-1:0]           mem_addr;
    logic [DW-1:0]           mem_dout;
    logic                    o_cell_fifo_wr;
    logic [NPORT-1:0]        o_cell_fifo_sel;
    logic [DW-1:0]           o_cell_fifo_din;
    logic                    o_cell_first;
    logic                    o_cell_last;
    logic [NPORT-1:0]        o_cell_bp;
    logic                    busy;

    modport sched (
        input  q_empty, q_head, mem_dout, o_cell_bp,
        output q_rd, mem_rd, mem_addr, o_cell_fifo_wr, o_cell_fifo_sel,
               o_cell_fifo_din, o_cell_first, o_cell_last, busy
    );

    modport env (
        output q_empty, q_head, mem_dout, o_cell_bp,
        input  q_rd, mem_rd, mem_addr, o_cell_fifo_wr, o_cell_fifo_sel,
               o_cell_fifo_din, o_cell_first, o_cell_last, busy
    );

endinterface

// File: rtl/rr_arb4.sv
// 4-way round-robin arbiter: combinational grant from req and pointer, pointer moves past winner on i_upd.
// Zero-latency grant; no back-pressure, callers mask ineligible requests.
module rr_arb4 (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] i_req,
    input  logic       i_upd,
    output logic [3:0] o_gnt,
    output logic [1:0] o_gnt_idx,
    output logic       o_any
);

    logic [1:0] r_rr;

    always_comb begin
        o_any     = 1'b0;
        o_gnt_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (!o_any && i_req[r_rr + 2'(k)]) begin
                o_any     = 1'b1;
                o_gnt_idx = r_rr + 2'(k);
            end
        end
        o_gnt = o_any ? (4'b0001 << o_gnt_idx) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr <= 2'd0;
        end else if (i_upd) begin
            r_rr <= o_gnt_idx + 2'd1;
        end
    end

endmodule

// File: rtl/switch_egress_sched.sv
// Egress frame scheduler: round-robin picks a port queue, streams its cells atomically, one grant cycle between frames.
// Cell appears one cycle after mem_rd; o_cell_bp of the granted port stalls issue, one in-flight cell may still land.
module switch_egress_sched
    import switch_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 128,
    parameter int CW = 6
) (
    input  logic                  clk,
    input  logic                  rstn,
    switch_egress_sched_if.sched  sched_if
);

    state_t             r_state;
    logic [1:0]         r_port;
    logic [AW-1:0]      r_addr;
    logic [CW-1:0]      r_rem;
    logic               r_first_pend;
    logic               r_wr;
    logic [NPORT-1:0]   r_sel;
    logic               r_first;
    logic               r_last;

    logic [START_W-1:0]     w_start [NPORT];
    logic [CNT_W-1:0]       w_cnt   [NPORT];
    logic [NPORT*RSV_W-1:0] w_unused_rsvd;

    for (genvar p = 0; p < NPORT; p++) begin : g_desc
        assign w_start[p] = sched_if.q_head[p*DESC_W + START_LSB +: START_W];
        assign w_cnt[p]   = sched_if.q_head[p*DESC_W + CNT_LSB   +: CNT_W];
        assign w_unused_rsvd[p*RSV_W +: RSV_W] = sched_if.q_head[p*DESC_W + RSV_LSB +: RSV_W];
    end

    logic [NPORT-1:0] w_req;
    logic [NPORT-1:0] w_gnt_oh;
    logic [1:0]       w_gnt_idx;
    logic             w_gnt_any;
    logic             w_grant;
    logic             w_gnt_zero;
    logic             w_issue;
    logic             w_issue_last;

    // Gating with rstn keeps q_rd/busy quiet while reset is held with queues loaded.
    assign w_req = ~sched_if.q_empty & ~sched_if.o_cell_bp & {NPORT{rstn}};

    rr_arb4 u_arb (
        .clk       (clk),
        .rstn      (rstn),
        .i_req     (w_req),
        .i_upd     (w_grant),
        .o_gnt     (w_gnt_oh),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_gnt_any)
    );

    assign w_grant      = (r_state == ST_IDLE) && w_gnt_any;
    assign w_gnt_zero   = w_grant && (w_cnt[w_gnt_idx] == '0);
    assign w_issue      = (r_state == ST_XFER) && !sched_if.o_cell_bp[r_port];
    assign w_issue_last = w_issue && (r_rem == CW'(1));

    always_comb begin
        sched_if.q_rd = '0;
        if (w_gnt_zero) begin
            sched_if.q_rd = w_gnt_oh;
        end else if (w_issue_last) begin
            sched_if.q_rd = onehot4(r_port);
        end
    end

    assign sched_if.mem_rd          = w_issue;
    assign sched_if.mem_addr        = w_issue ? r_addr : '0;
    assign sched_if.o_cell_fifo_wr  = r_wr;
    assign sched_if.o_cell_fifo_sel = r_sel;
    assign sched_if.o_cell_first    = r_first;
    assign sched_if.o_cell_last     = r_last;
    assign sched_if.o_cell_fifo_din = r_wr ? sched_if.mem_dout : '0;
    assign sched_if.busy            = (r_state == ST_XFER) || r_wr || w_grant;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_port       <= 2'd0;
            r_addr       <= '0;
            r_rem        <= '0;
            r_first_pend <= 1'b0;
            r_wr         <= 1'b0;
            r_sel        <= '0;
            r_first      <= 1'b0;
            r_last       <= 1'b0;
        end else begin
            r_wr    <= w_issue;
            r_sel   <= w_issue ? onehot4(r_port) : '0;
            r_first <= w_issue && r_first_pend;
            r_last  <= w_issue_last;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_port       <= w_gnt_idx;
                        r_addr       <= AW'(w_start[w_gnt_idx]);
                        r_rem        <= CW'(w_cnt[w_gnt_idx]);
                        r_first_pend <= 1'b1;
                        if (!w_gnt_zero) begin
                            r_state <= ST_XFER;
                        end
                    end
                end
                ST_XFER: begin
                    if (w_issue) begin
                        r_addr       <= r_addr + AW'(1);
                        r_rem        <= r_rem - CW'(1);
                        r_first_pend <= 1'b0;
                        if (w_issue_last) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_switch_egress_sched.sv
// Bench for switch_egress_sched: directed scenarios plus randomized traffic against a frame-level model.
module tb_switch_egress_sched;
    import switch_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    switch_egress_sched_if #(.AW(8), .DW(128)) sif ();

    switch_egress_sched #(.AW(8), .DW(128), .CW(6)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .sched_if (sif)
    );

    typedef struct { int port; int start; int cnt; } desc_t;
    typedef struct { int port; int addr; bit first; bit last; } cell_t;
    typedef struct { int cyc; logic [3:0] sel; bit first; bit last; } ocell_t;
    typedef struct { int cyc; logic [3:0] v; } qrd_t;

    desc_t  dq[$];
    cell_t  exp_frame[$];
    bit     p_vld;
    cell_t  p_cell;
    int     m_rr;
    int     m_port;
    int     obs_addr[$];
    int     obs_rdcyc[$];
    ocell_t obs_cell[$];
    qrd_t   obs_qrd[$];
    int     cyc, n_chk, n_fail;
    logic [3:0] bp;
    logic [7:0] salt;

    function automatic logic [127:0] pattern(input int a);
        logic [7:0] b;
        b = a[7:0];
        return {8{b ^ salt, ~b}};
    endfunction

    function automatic int head_idx(input int p);
        for (int i = 0; i < dq.size(); i++) if (dq[i].port == p) return i;
        return -1;
    endfunction

    task automatic push(input int p, input int s, input int c);
        desc_t d;
        d.port = p; d.start = s; d.cnt = c;
        dq.push_back(d);
    endtask

    task automatic drive_q();
        for (int p = 0; p < 4; p++) begin
            int i;
            i = head_idx(p);
            sif.q_empty[p] = (i < 0);
            sif.q_head[p*16 +: 16] = (i < 0) ? 16'h0 : {2'b10, 6'(dq[i].cnt), 8'(dq[i].start)};
        end
        sif.o_cell_bp = bp;
    endtask

    task automatic clear_obs();
        obs_addr.delete(); obs_rdcyc.delete(); obs_cell.delete(); obs_qrd.delete();
    endtask

    // One clock: model the cycle from spec rules, compare at negedge, apply pops after posedge.
    task automatic tick();
        bit busy_before, grant, s_rd;
        logic [3:0] eq, s_qrd, esel;
        bit erd;
        int eaddr, g, s_addr;
        cell_t c;
        @(negedge clk);
        eq = 4'h0; erd = 1'b0; eaddr = 0; grant = 1'b0; g = -1;
        busy_before = (exp_frame.size() != 0);
        if (!busy_before) begin
            for (int k = 0; k < 4; k++) begin
                int p;
                p = (m_rr + k) % 4;
                if (g < 0 && head_idx(p) >= 0 && !bp[p]) g = p;
            end
            if (g >= 0) begin
                desc_t d;
                d = dq[head_idx(g)];
                grant = 1'b1;
                m_rr = (g + 1) % 4;
                if (d.cnt == 0) eq = 4'(1 << g);
                else begin
                    m_port = g;
                    for (int i = 0; i < d.cnt; i++) begin
                        cell_t nc;
                        nc.port = g; nc.addr = (d.start + i) % 256;
                        nc.first = (i == 0); nc.last = (i == d.cnt - 1);
                        exp_frame.push_back(nc);
                    end
                end
            end
        end else if (!bp[m_port]) begin
            c = exp_frame.pop_front();
            erd = 1'b1; eaddr = c.addr;
            if (c.last) eq = 4'(1 << m_port);
        end
        esel = p_vld ? 4'(1 << p_cell.port) : 4'h0;
        n_chk++; if (sif.q_rd !== eq) begin n_fail++; $display("FAIL q_rd cyc=%0d got=%b exp=%b", cyc, sif.q_rd, eq); end
        n_chk++; if (sif.mem_rd !== erd) begin n_fail++; $display("FAIL mem_rd cyc=%0d got=%b exp=%b", cyc, sif.mem_rd, erd); end
        n_chk++; if (sif.mem_addr !== 8'(eaddr)) begin n_fail++; $display("FAIL mem_addr cyc=%0d got=%h exp=%h", cyc, sif.mem_addr, 8'(eaddr)); end
        n_chk++; if (sif.busy !== (busy_before || grant || p_vld)) begin n_fail++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, sif.busy, busy_before || grant || p_vld); end
        n_chk++; if (sif.o_cell_fifo_wr !== p_vld) begin n_fail++; $display("FAIL cell_wr cyc=%0d got=%b exp=%b", cyc, sif.o_cell_fifo_wr, p_vld); end
        n_chk++; if (sif.o_cell_fifo_sel !== esel) begin n_fail++; $display("FAIL cell_sel cyc=%0d got=%b exp=%b", cyc, sif.o_cell_fifo_sel, esel); end
        n_chk++; if ({sif.o_cell_first, sif.o_cell_last} !== {p_vld && p_cell.first, p_vld && p_cell.last}) begin
            n_fail++; $display("FAIL first_last cyc=%0d got=%b%b exp=%b%b", cyc, sif.o_cell_first, sif.o_cell_last, p_vld && p_cell.first, p_vld && p_cell.last);
        end
        n_chk++; if (sif.o_cell_fifo_din !== (p_vld ? pattern(p_cell.addr) : 128'h0)) begin
            n_fail++; $display("FAIL cell_din cyc=%0d got=%h", cyc, sif.o_cell_fifo_din);
        end
        if (sif.mem_rd) begin obs_addr.push_back(int'(sif.mem_addr)); obs_rdcyc.push_back(cyc); end
        if (sif.o_cell_fifo_wr) obs_cell.push_back('{cyc, sif.o_cell_fifo_sel, sif.o_cell_first, sif.o_cell_last});
        if (|sif.q_rd) obs_qrd.push_back('{cyc, sif.q_rd});
        s_qrd = sif.q_rd; s_rd = sif.mem_rd; s_addr = int'(sif.mem_addr);
        p_vld = erd;
        p_cell = c;
        @(posedge clk);
        #1;
        cyc++;
        for (int p = 0; p < 4; p++) begin
            if (s_qrd[p]) begin
                int i;
                i = head_idx(p);
                if (i >= 0) dq.delete(i);
            end
        end
        if (s_rd) sif.mem_dout = pattern(s_addr);
        drive_q();
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((dq.size() != 0 || exp_frame.size() != 0 || p_vld) && n < budget) begin
            tick();
            n++;
        end
        n_chk++; if (n >= budget) begin n_fail++; $display("FAIL idle_timeout got=%0d cycles exp<%0d", n, budget); end
    endtask

    task automatic test_reset();
        rstn = 1'b0; bp = 4'h0; sif.mem_dout = '0; salt = 8'($urandom);
        dq.delete(); exp_frame.delete(); p_vld = 1'b0; m_rr = 0; cyc = 0;
        push(2, 8'h10, 3);
        drive_q();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++; if ({sif.q_rd, sif.mem_rd, sif.mem_addr, sif.busy} !== 14'h0) begin
            n_fail++; $display("FAIL reset_ctrl got=%h exp=0", {sif.q_rd, sif.mem_rd, sif.mem_addr, sif.busy});
        end
        n_chk++; if ({sif.o_cell_fifo_wr, sif.o_cell_fifo_sel, sif.o_cell_first, sif.o_cell_last} !== 7'h0) begin
            n_fail++; $display("FAIL reset_cell got=%h exp=0", {sif.o_cell_fifo_wr, sif.o_cell_fifo_sel, sif.o_cell_first, sif.o_cell_last});
        end
        dq.delete();
        drive_q();
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_sel [5];
        exp_sel = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        clear_obs();
        push(0, 8'h20, 1); push(1, 8'h21, 1); push(2, 8'h22, 1); push(3, 8'h23, 1); push(0, 8'h24, 1);
        drive_q();
        run_until_idle(100);
        n_chk++; if (obs_cell.size() != 5) begin n_fail++; $display("FAIL rr_count got=%0d exp=5", obs_cell.size()); end
        else for (int i = 0; i < 5; i++) begin
            n_chk++; if (obs_cell[i].sel !== exp_sel[i]) begin n_fail++; $display("FAIL rr_order[%0d] got=%b exp=%b", i, obs_cell[i].sel, exp_sel[i]); end
            if (i < 4) begin
                n_chk++; if (obs_rdcyc[i+1] - obs_rdcyc[i] != 2) begin n_fail++; $display("FAIL rr_gap[%0d] got=%0d exp=2", i, obs_rdcyc[i+1] - obs_rdcyc[i]); end
            end
        end
    endtask

    task automatic test_single_frame();
        clear_obs();
        push(2, 8'h10, 3);
        drive_q();
        run_until_idle(50);
        n_chk++; if (obs_addr.size() != 3 || obs_cell.size() != 3) begin
            n_fail++; $display("FAIL sf_count got=%0d/%0d exp=3/3", obs_addr.size(), obs_cell.size());
        end else for (int i = 0; i < 3; i++) begin
            n_chk++; if (obs_addr[i] != 16 + i) begin n_fail++; $display("FAIL sf_addr[%0d] got=%h exp=%h", i, obs_addr[i], 16 + i); end
            n_chk++; if (obs_rdcyc[i] != obs_rdcyc[0] + i) begin n_fail++; $display("FAIL sf_consec[%0d] got=%0d exp=%0d", i, obs_rdcyc[i], obs_rdcyc[0] + i); end
            n_chk++; if (obs_cell[i].cyc != obs_rdcyc[i] + 1 || obs_cell[i].sel !== 4'b0100) begin
                n_fail++; $display("FAIL sf_cell[%0d] got=cyc%0d sel%b exp=cyc%0d sel0100", i, obs_cell[i].cyc, obs_cell[i].sel, obs_rdcyc[i] + 1);
            end
            n_chk++; if (obs_cell[i].first != (i == 0) || obs_cell[i].last != (i == 2)) begin
                n_fail++; $display("FAIL sf_flags[%0d] got=%b%b", i, obs_cell[i].first, obs_cell[i].last);
            end
        end
        n_chk++; if (obs_qrd.size() != 1 || obs_addr.size() != 3) begin n_fail++; $display("FAIL sf_qrd_count got=%0d exp=1", obs_qrd.size()); end
        else begin
            n_chk++; if (obs_qrd[0].v !== 4'b0100 || obs_qrd[0].cyc != obs_rdcyc[2]) begin
                n_fail++; $display("FAIL sf_qrd got=%b@%0d exp=0100@%0d", obs_qrd[0].v, obs_qrd[0].cyc, obs_rdcyc[2]);
            end
        end
    endtask

    task automatic test_back_pressure();
        int n;
        clear_obs();
        push(1, 8'h40, 4);
        drive_q();
        n = 0;
        while (obs_addr.size() < 2 && n < 20) begin tick(); n++; end
        bp = 4'b0010; drive_q();
        repeat (3) tick();
        bp = 4'b0000; drive_q();
        run_until_idle(50);
        n_chk++; if (obs_addr.size() != 4 || obs_cell.size() != 4) begin
            n_fail++; $display("FAIL bp_count got=%0d/%0d exp=4/4", obs_addr.size(), obs_cell.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_chk++; if (obs_addr[i] != 64 + i || obs_cell[i].last != (i == 3) || obs_cell[i].first != (i == 0)) begin
                    n_fail++; $display("FAIL bp_cell[%0d] got=%h f%b l%b exp=%h", i, obs_addr[i], obs_cell[i].first, obs_cell[i].last, 64 + i);
                end
            end
            n_chk++; if (obs_rdcyc[2] - obs_rdcyc[1] != 4) begin n_fail++; $display("FAIL bp_stall got=%0d exp=4", obs_rdcyc[2] - obs_rdcyc[1]); end
        end
        push(0, 8'h50, 1);
        drive_q();
        run_until_idle(20);
        clear_obs();
        push(1, 8'h60, 2); push(3, 8'h70, 1);
        bp = 4'b0010; drive_q();
        n = 0;
        while (obs_cell.size() < 1 && n < 20) begin tick(); n++; end
        bp = 4'b0000; drive_q();
        run_until_idle(50);
        n_chk++; if (obs_cell.size() != 3) begin n_fail++; $display("FAIL bp_skip_count got=%0d exp=3", obs_cell.size()); end
        else begin
            n_chk++; if (obs_cell[0].sel !== 4'b1000 || obs_cell[1].sel !== 4'b0010) begin
                n_fail++; $display("FAIL bp_skip got=%b,%b exp=1000,0010", obs_cell[0].sel, obs_cell[1].sel);
            end
        end
    endtask

    task automatic test_wrap_bounds();
        clear_obs();
        push(0, 8'hFE, 3);
        drive_q();
        run_until_idle(30);
        n_chk++; if (obs_addr.size() != 3) begin n_fail++; $display("FAIL wrap_count got=%0d exp=3", obs_addr.size()); end
        else begin
            n_chk++; if (obs_addr[0] != 8'hFE || obs_addr[1] != 8'hFF || obs_addr[2] != 8'h00) begin
                n_fail++; $display("FAIL wrap_addr got=%h %h %h exp=fe ff 00", obs_addr[0], obs_addr[1], obs_addr[2]);
            end
        end
        clear_obs();
        push(2, 8'h33, 0);
        drive_q();
        run_until_idle(20);
        n_chk++; if (obs_cell.size() != 0 || obs_addr.size() != 0) begin n_fail++; $display("FAIL zero_cells got=%0d exp=0", obs_cell.size()); end
        n_chk++; if (obs_qrd.size() != 1) begin n_fail++; $display("FAIL zero_qrd_count got=%0d exp=1", obs_qrd.size()); end
        else begin
            n_chk++; if (obs_qrd[0].v !== 4'b0100) begin n_fail++; $display("FAIL zero_qrd got=%b exp=0100", obs_qrd[0].v); end
        end
        clear_obs();
        push(3, 8'h34, 1);
        drive_q();
        run_until_idle(20);
        n_chk++; if (obs_cell.size() != 1) begin n_fail++; $display("FAIL one_count got=%0d exp=1", obs_cell.size()); end
        else begin
            n_chk++; if (!obs_cell[0].first || !obs_cell[0].last) begin n_fail++; $display("FAIL one_flags got=%b%b exp=11", obs_cell[0].first, obs_cell[0].last); end
        end
    endtask

    task automatic test_random();
        int pushed;
        pushed = 0;
        clear_obs();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0 && dq.size() < 12) begin
                push($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 9));
                pushed++;
            end
            bp = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            drive_q();
            tick();
        end
        bp = 4'h0; drive_q();
        run_until_idle(2000);
        n_chk++; if (obs_qrd.size() != pushed) begin n_fail++; $display("FAIL rand_pops got=%0d exp=%0d", obs_qrd.size(), pushed); end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_obs();
        push(1, 8'h80, 5);
        drive_q();
        n = 0;
        while (obs_addr.size() < 1 && n < 20) begin tick(); n++; end
        #2;
        n_chk++; if (sif.mem_rd !== 1'b1 || sif.mem_addr !== 8'h81) begin
            n_fail++; $display("FAIL mid_pre got=%b@%h exp=1@81", sif.mem_rd, sif.mem_addr);
        end
        rstn = 1'b0;
        #1;
        n_chk++; if ({sif.q_rd, sif.mem_rd, sif.mem_addr, sif.busy} !== 14'h0) begin
            n_fail++; $display("FAIL mid_rst_ctrl got=%h exp=0", {sif.q_rd, sif.mem_rd, sif.mem_addr, sif.busy});
        end
        n_chk++; if ({sif.o_cell_fifo_wr, sif.o_cell_fifo_sel, sif.o_cell_first, sif.o_cell_last} !== 7'h0 || sif.o_cell_fifo_din !== 128'h0) begin
            n_fail++; $display("FAIL mid_rst_cell got=%b%b exp=0", sif.o_cell_fifo_wr, sif.o_cell_fifo_sel);
        end
        exp_frame.delete(); p_vld = 1'b0; m_rr = 0;
        push(2, 8'h90, 1);
        drive_q();
        @(posedge clk);
        #1 rstn = 1'b1;
        clear_obs();
        run_until_idle(50);
        n_chk++; if (obs_addr.size() != 6 || obs_cell.size() != 6) begin
            n_fail++; $display("FAIL mid_count got=%0d exp=6", obs_addr.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_chk++; if (obs_addr[i] != 128 + i) begin n_fail++; $display("FAIL mid_addr[%0d] got=%h exp=%h", i, obs_addr[i], 128 + i); end
            end
            n_chk++; if (obs_cell[0].sel !== 4'b0010 || obs_cell[5].sel !== 4'b0100) begin
                n_fail++; $display("FAIL mid_order got=%b,%b exp=0010,0100", obs_cell[0].sel, obs_cell[5].sel);
            end
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        test_reset();
        test_round_robin();
        test_single_frame();
        test_back_pressure();
        test_wrap_bounds();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_egress_sched.md
Name: switch_egress_sched

Overview:
- Egress frame scheduler between the shared cell buffer and switch_post_top.
- Selects one of 4 per-port frame-descriptor queues round-robin, skipping back-pressured ports, and reads that frame's cells from the cell memory one per cycle.
- Drives the o_cell_* write interface, keeping every frame atomic from first cell to last cell.
- Pops the descriptor once the frame's last cell has been issued.

Parameters:
- NPORT, 4, number of output ports; fixed at 4, one-hot select width.
- AW, 8, cell memory address width.
- DW, 128, cell width in bits.
- CW, 6, descriptor cell-count width.

Ports:
- clk  in  1  core clock.
- rstn  in  1  asynchronous active-low reset.
- q_empty  in  4  per-port descriptor queue empty flag.
- q_head  in  64  per-port head descriptor (port p at [16p+15:16p]): [7:0] start cell address, [13:8] cell count, [15:14] reserved.
- q_rd  out  4  one-hot, one-cycle descriptor pop.
- mem_rd  out  1  cell memory read strobe.
- mem_addr  out  AW  cell memory read address.
- mem_dout  in  DW  cell memory read data; valid 1 cycle after mem_rd.
- o_cell_fifo_wr  out  1  cell write strobe to switch_post_top.
- o_cell_fifo_sel  out  4  one-hot destination port.
- o_cell_fifo_din  out  DW  cell data, equal to mem_dout.
- o_cell_first  out  1  first cell of a frame.
- o_cell_last  out  1  last cell of a frame.
- o_cell_bp  in  4  per-port back-pressure from switch_post_top.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset values:
  - All registered outputs 0.
  - Round-robin pointer rr = 0, so port 0 has highest priority first.
  - FSM in IDLE.
- Eligibility: port p is eligible when !q_empty[p] && !o_cell_bp[p].
- FSM states: IDLE, XFER.
- IDLE:
  - With no eligible port, stay in IDLE.
  - Otherwise grant the first eligible port searching rr, rr+1, ... mod 4.
  - On grant: latch port g, addr = q_head[g][7:0], rem = q_head[g][13:8]; set rr = g+1 mod 4; go to XFER.
  - No mem_rd is issued in the grant cycle.
- Zero-length descriptor (count 0):
  - On grant, pulse q_rd[g] in the grant cycle, issue no cells, stay in IDLE.
  - rr still advances past g.
- XFER, per cycle:
  - If o_cell_bp[g] = 1: stall. No mem_rd; addr and rem hold.
  - Else: mem_rd = 1, mem_addr = addr; addr <= addr+1, wrapping mod 2^AW (0xFF -> 0x00); rem <= rem-1.
  - When the issued cell is the last one (rem == 1): pulse q_rd[g] in the same cycle and return to IDLE.
- Back-pressure:
  - o_cell_bp of non-granted ports has no effect during XFER.
  - o_cell_bp is sampled at issue time. Because of the 1-cycle read pipeline, one more cell can be written after bp rises; downstream provides one cell of slack.
- Output pipeline:
  - mem_rd in cycle N produces o_cell_fifo_wr = 1 in cycle N+1, with o_cell_fifo_din = mem_dout.
  - o_cell_fifo_sel = onehot(g), o_cell_first and o_cell_last are registered from cycle N.
  - o_cell_first marks the first issued cell of the frame; o_cell_last marks the cell issued with rem == 1.
  - A 1-cell frame has first = last = 1.
  - When o_cell_fifo_wr = 0, sel/first/last are 0.
- Throughput:
  - One idle cycle (the grant cycle) between frames.
  - Back-to-back cells within a frame when not back-pressured.
- busy: 1 from the grant cycle until the cycle after the last cell's mem_rd, inclusive of the final o_cell_fifo_wr.
- Queue interface:
  - q_head must stay stable while q_empty = 0 and no q_rd is pending.
  - q_rd is never asserted for an empty queue.
- Mid-frame reset: all state and outputs clear immediately. The partial frame is abandoned without o_cell_last and no q_rd is issued.

Decomposition:
- Shared package switch_pkg holds:
  - Descriptor field positions: START_LSB = 0, START_W = 8, CNT_LSB = 8, CNT_W = 6.
  - NPORT and state encodings.
- Sub-module rr_arb4: 4-input round-robin arbiter, combinational grant from {req, rr} plus a registered pointer update enable.
- Everything else lives in the top FSM.

Test Plan:
- Single frame:
  - Stimulus: port 2 descriptor start = 0x10, count = 3, no bp.
  - Required: mem_addr 0x10, 0x11, 0x12 on consecutive cycles.
  - Required: o_cell_fifo_wr on the 3 following cycles with sel = 0100, first on cell 0, last on cell 2.
  - Required: q_rd = 0100 in the cycle 0x12 is issued.
- Round robin:
  - Stimulus: all 4 queues hold 1-cell frames, rr = 0.
  - Required: grant order 0, 1, 2, 3, 0, with one grant cycle between frames.
- Back-pressure:
  - Stimulus: port 1, 4-cell frame; o_cell_bp[1] asserted for 3 cycles after the 2nd cell is issued.
  - Required: no mem_rd during the stall; addr resumes at start+2; last-cell flag still correct.
  - Stimulus: o_cell_bp[1] high at arbitration while port 3 is eligible.
  - Required: port 3 is granted.
- Wrap and boundaries:
  - Stimulus: start = 0xFE, count = 3.
  - Required: addresses 0xFE, 0xFF, 0x00.
  - Stimulus: count = 0.
  - Required: q_rd pulse only, no o_cell_fifo_wr.
  - Stimulus: count = 1.
  - Required: first = last = 1.
- Reset mid-frame:
  - Stimulus: assert rstn low during the 2nd cell of a 5-cell frame.
  - Required: outputs 0 asynchronously; after release, the same descriptor is re-served from its start address with rr = 0.
